// File: rtl/relu1_stage_if.sv
// Memory-side bus of relu1_stage: asynchronous read port of the layer-1 result
// memory and synchronous write port of the next layer's input memory.
interface relu1_stage_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mm_read_addr;
    logic [31:0]       mm_data;
    logic [ADDR_W-1:0] out_write_addr;
    logic [31:0]       out_data;
    logic              out_write_enable;

    modport master (
        output mm_read_addr,
        input  mm_data,
        output out_write_addr,
        output out_data,
        output out_write_enable
    );

    modport slave (
        input  mm_read_addr,
        output mm_data,
        input  out_write_addr,
        input  out_data,
        input  out_write_enable
    );
endinterface

// File: rtl/relu1_stage.sv
// Layer-1 activation stage: streams N words from the matmul result memory through
// ReLU, arithmetic right shift and a saturating clamp into the next layer's memory.
module relu1_stage #(
    parameter int unsigned N       = 64,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SHIFT   = 0,
    parameter logic [31:0] SAT_MAX = 32'd2147483647
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    relu1_stage_if.master     mem_if,
    output logic              busy,
    output logic              done,
    output logic [6:0]        nz_count
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]      data_q, data_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [6:0]       nz_q, nz_d;
    logic [31:0]      act_c;

    // Input is non-negative once the sign check passes, so a logical shift
    // matches the arithmetic one and the clamp compare can be unsigned.
    function automatic logic [31:0] act_f(input logic [31:0] x);
        logic [31:0] y;
        y = x >> SHIFT;
        if (x[31])            return 32'd0;
        else if (y > SAT_MAX) return SAT_MAX;
        else                  return y;
    endfunction

    assign act_c = act_f(mem_if.mm_data);

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        data_d   = data_q;
        we_d     = we_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        nz_d     = nz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    rd_idx_d = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                data_d   = act_c;
                wr_idx_d = rd_idx_q;
                we_d     = 1'b1;
                if (act_c != 32'd0) cnt_d = cnt_q + 7'd1;
                if (rd_idx_q == LAST_IDX) state_d  = S_FLUSH;
                else                      rd_idx_d = rd_idx_q + IDX_W'(1);
            end
            S_FLUSH: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                nz_d    = cnt_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            nz_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            data_q   <= data_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            nz_q     <= nz_d;
        end
    end

    assign mem_if.mm_read_addr     = ADDR_W'(rd_idx_q);
    assign mem_if.out_write_addr   = ADDR_W'(wr_idx_q);
    assign mem_if.out_data         = data_q;
    assign mem_if.out_write_enable = we_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign nz_count                = nz_q;

endmodule

// File: tb/tb_relu1_stage.sv
// Bench for relu1_stage: two instances (default parameters and SHIFT=4/SAT_MAX=1000)
// sharing clock, reset and start, each with its own source and sink memories.
module tb_relu1_stage;

    localparam int NE = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy_a, done_a, busy_b, done_b;
    logic [6:0] nz_a, nz_b;

    relu1_stage_if #(.ADDR_W(16)) bus_a ();
    relu1_stage_if #(.ADDR_W(16)) bus_b ();

    relu1_stage #(.N(64), .ADDR_W(16), .SHIFT(0), .SAT_MAX(32'd2147483647)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_if(bus_a.master),
        .busy(busy_a), .done(done_a), .nz_count(nz_a));

    relu1_stage #(.N(64), .ADDR_W(16), .SHIFT(4), .SAT_MAX(32'd1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_if(bus_b.master),
        .busy(busy_b), .done(done_b), .nz_count(nz_b));

    always #5 clk = ~clk;

    logic [31:0] mem_a [NE];
    logic [31:0] mem_b [NE];
    logic [31:0] wr_a  [NE];
    logic [31:0] wr_b  [NE];

    assign bus_a.mm_data = mem_a[bus_a.mm_read_addr[5:0]];
    assign bus_b.mm_data = mem_b[bus_b.mm_read_addr[5:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int wcnt_a = 0, wcnt_b = 0;
    int order_err = 0;
    int addr_err = 0;
    int done_cnt = 0;
    int we_run = 0, we_run_last = 0;

    // Sink memories: commit on the clock edge, as the downstream write port would
    always @(posedge clk) begin
        if (bus_a.out_write_enable) begin
            if (bus_a.out_write_addr != 16'(wcnt_a)) order_err++;
            wr_a[bus_a.out_write_addr[5:0]] = bus_a.out_data;
            wcnt_a++;
        end
        if (bus_b.out_write_enable) begin
            if (bus_b.out_write_addr != 16'(wcnt_b)) order_err++;
            wr_b[bus_b.out_write_addr[5:0]] = bus_b.out_data;
            wcnt_b++;
        end
    end

    always @(negedge clk) begin
        if (bus_a.mm_read_addr > 16'd63 || bus_a.out_write_addr > 16'd63) addr_err++;
        if (done_a) done_cnt++;
        if (bus_a.out_write_enable) we_run++;
        else if (we_run != 0) begin
            we_run_last = we_run;
            we_run = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wcnt_a = 0; wcnt_b = 0; order_err = 0; done_cnt = 0;
        we_run = 0; we_run_last = 0;
        for (int i = 0; i < NE; i++) begin
            wr_a[i] = 32'hDEADBEEF;
            wr_b[i] = 32'hDEADBEEF;
        end
    endtask

    // Accept start at E0, optionally re-pulse start at two edge counts, wait for done.
    task automatic do_pass(input int p1, input int p2, output int edges);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy_a), 32'd1);
        chk("rd_addr_after_start", 32'(bus_a.mm_read_addr), 32'd0);
        edges = 0;
        while (!done_a && edges < 200) begin
            start = (edges == p1 || edges == p2) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        chk("pass_len_edges", 32'(edges), 32'd65);
        chk("busy_at_done", 32'(busy_a), 32'd0);
    endtask

    task automatic check_ramp(input string tag);
        for (int i = 0; i < NE; i++) begin
            chk($sformatf("%s_wr[%0d]", tag, i), wr_a[i], (i < 32) ? 32'd0 : 32'(i - 32));
        end
        chk({tag, "_nz"}, 32'(nz_a), 32'd31);
        chk({tag, "_wcnt"}, 32'(wcnt_a), 32'd64);
        chk({tag, "_order"}, 32'(order_err), 32'd0);
        chk({tag, "_we_run"}, 32'(we_run_last), 32'd64);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NE; i++) begin
            mem_a[i] = 32'(i - 32);
            mem_b[i] = 32'(i - 32);
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [11];
    int   edges;
    int   nz_exp_a, nz_exp_b;
    int   snap;

    initial begin
        // x, expected with SHIFT=0/no clamp, expected with SHIFT=4/SAT_MAX=1000
        vecs[0]  = '{32'hFFFFFFFB, 32'd0,          32'd0};
        vecs[1]  = '{32'd15,       32'd15,         32'd0};
        vecs[2]  = '{32'd16,       32'd16,         32'd1};
        vecs[3]  = '{32'd160000,   32'd160000,     32'd1000};
        vecs[4]  = '{32'd0,        32'd0,          32'd0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd0,          32'd0};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF,   32'd1000};
        vecs[7]  = '{32'h80000000, 32'd0,          32'd0};
        vecs[8]  = '{32'd16015,    32'd16015,      32'd1000};
        vecs[9]  = '{32'd16031,    32'd16031,      32'd1000};
        vecs[10] = '{32'd15999,    32'd15999,      32'd999};
        nz_exp_a = 7;
        nz_exp_b = 6;

        // Reset then idle
        load_ramp();
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_we", 32'(bus_a.out_write_enable), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_done", 32'(done_a), 32'd0);
        chk("idle_rd_addr", 32'(bus_a.mm_read_addr), 32'd0);
        chk("idle_wr_addr", 32'(bus_a.out_write_addr), 32'd0);
        chk("idle_data", bus_a.out_data, 32'd0);
        chk("idle_nz", 32'(nz_a), 32'd0);
        chk("idle_writes", 32'(wcnt_a), 32'd0);

        // Ramp x[i] = i-32 with pass-through transfer
        do_pass(-1, -1, edges);
        chk("ramp_done_pulse", 32'(done_a), 32'd1);
        @(posedge clk); #1;
        chk("ramp_done_drop", 32'(done_a), 32'd0);
        check_ramp("ramp");

        // Table of transfer-function corner values on both configurations
        for (int i = 0; i < NE; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        for (int i = 0; i < 11; i++) begin
            mem_a[i] = vecs[i].x;
            mem_b[i] = vecs[i].x;
        end
        chk("nz_held_before_pass", 32'(nz_a), 32'd31);
        do_pass(-1, -1, edges);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl_a[%0d]", i), wr_a[i], vecs[i].exp_a);
            chk($sformatf("tbl_b[%0d]", i), wr_b[i], vecs[i].exp_b);
        end
        chk("tbl_a_tail", wr_a[63], 32'd0);
        chk("tbl_b_tail", wr_b[40], 32'd0);
        chk("tbl_nz_a", 32'(nz_a), 32'(nz_exp_a));
        chk("tbl_nz_b", 32'(nz_b), 32'(nz_exp_b));
        chk("tbl_wcnt_b", 32'(wcnt_b), 32'd64);

        // All entries most negative
        for (int i = 0; i < NE; i++) begin
            mem_a[i] = 32'h80000000;
            mem_b[i] = 32'h80000000;
        end
        do_pass(-1, -1, edges);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NE; i += 9) begin
            chk($sformatf("neg_a[%0d]", i), wr_a[i], 32'd0);
            chk($sformatf("neg_b[%0d]", i), wr_b[i], 32'd0);
        end
        chk("neg_a_last", wr_a[63], 32'd0);
        chk("neg_nz_a", 32'(nz_a), 32'd0);
        chk("neg_nz_b", 32'(nz_b), 32'd0);

        // Start re-pulsed mid-pass must be ignored
        load_ramp();
        do_pass(10, 40, edges);
        repeat (6) @(posedge clk);
        #1;
        chk("repulse_done_count", 32'(done_cnt), 32'd1);
        chk("repulse_busy_after", 32'(busy_a), 32'd0);
        check_ramp("repulse");

        // Start held high: back-to-back passes separated by one idle cycle
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        edges = 0;
        while (!done_a && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("hold_pass_len", 32'(edges), 32'd65);
        @(posedge clk); #1;
        chk("hold_idle_busy", 32'(busy_a), 32'd0);
        chk("hold_idle_done", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        chk("hold_restart_busy", 32'(busy_a), 32'd1);
        chk("hold_restart_addr", 32'(bus_a.mm_read_addr), 32'd0);
        start = 1'b0;
        edges = 0;
        while (!done_a && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("hold_second_len", 32'(edges), 32'd65);
        chk("hold_wcnt", 32'(wcnt_a), 32'd128);
        repeat (2) @(posedge clk);

        // Reset asserted at cycle 20 of a pass
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_we_drop", 32'(bus_a.out_write_enable), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rd_addr", 32'(bus_a.mm_read_addr), 32'd0);
        chk("rst_nz", 32'(nz_a), 32'd0);
        chk("rst_writes_before", 32'(wcnt_a), 32'd19);
        snap = wcnt_a;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_late_writes", 32'(wcnt_a), 32'(snap));
        do_pass(-1, -1, edges);
        repeat (2) @(posedge clk);
        #1;
        check_ramp("post_rst");
        chk("addr_range", 32'(addr_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
